// File: rtl/img_capture_packer_pkg.sv
// Shared types and helpers for the image capture/packing datapath.
package img_proc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        FLUSH   = 3'd4
    } cap_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/img_capture_packer_if.sv
// CCD stream in, Dmem write port and status out, grouped for the capture block.
interface img_capture_packer_if #(
    parameter int PXL_W  = 16,
    parameter int PACK   = 16,
    parameter int ADDR_W = 7
);
    logic                    iCCD_enable;
    logic                    iCCD_start;
    logic                    iFVAL;
    logic                    iDVAL;
    logic [PXL_W-1:0]        iDATA;
    logic                    oDmem_wren;
    logic [ADDR_W-1:0]       oDmem_addr;
    logic [PACK*PXL_W-1:0]   oDmem_data;
    logic                    oCCD_busy;
    logic                    oCCD_done;
    logic                    oCCD_err;

    modport master (
        output iCCD_enable, iCCD_start, iFVAL, iDVAL, iDATA,
        input  oDmem_wren, oDmem_addr, oDmem_data, oCCD_busy, oCCD_done, oCCD_err
    );

    modport slave (
        input  iCCD_enable, iCCD_start, iFVAL, iDVAL, iDATA,
        output oDmem_wren, oDmem_addr, oDmem_data, oCCD_busy, oCCD_done, oCCD_err
    );
endinterface

// File: rtl/img_capture_packer_pixel_packer.sv
// Lane register: pixels land in fixed lanes by index; the word auto-clears after the last lane.
module pixel_packer #(
    parameter int PXL_W  = 16,
    parameter int PACK   = 16,
    parameter int LIDX_W = (PACK > 1) ? $clog2(PACK) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic                  clear_i,
    input  logic [PXL_W-1:0]      pixel_i,
    output logic [PACK*PXL_W-1:0] word_o,
    output logic                  word_full_o,
    output logic [LIDX_W-1:0]     lane_o
);
    logic [PACK-1:0][PXL_W-1:0] lanes_q, lanes_d;
    logic [LIDX_W-1:0]          idx_q;

    // word_o already includes the pixel being pushed this cycle
    always_comb begin
        lanes_d = lanes_q;
        if (push_i) lanes_d[idx_q] = pixel_i;
    end

    assign word_o      = lanes_d;
    assign word_full_o = push_i && (idx_q == LIDX_W'(PACK - 1));
    assign lane_o      = idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q <= '0;
            idx_q   <= '0;
        end else if (clear_i || word_full_o) begin
            lanes_q <= '0;
            idx_q   <= '0;
        end else if (push_i) begin
            lanes_q <= lanes_d;
            idx_q   <= idx_q + LIDX_W'(1);
        end
    end
endmodule

// File: rtl/img_capture_packer.sv
// Captures one armed frame from the CCD stream and writes it to Dmem as packed words.
module img_capture_packer
    import img_proc_pkg::*;
#(
    parameter int PXL_W      = 16,
    parameter int IMG_PIXELS = 784,
    parameter int PACK       = 16,
    parameter int ADDR_W     = 7,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    img_capture_packer_if.slave bus
);
    localparam int WORDS  = ceil_div(IMG_PIXELS, PACK);
    localparam int CNT_W  = $clog2(IMG_PIXELS + 1);
    localparam int LIDX_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IMG_PIXELS);

    if (BASE_ADDR + WORDS > (1 << ADDR_W)) begin : g_addr_range_chk
        $error("img_capture_packer: frame does not fit in the Dmem address space");
    end

    cap_state_t             state_q, state_d;
    logic                   fval_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d, waddr_q, waddr_d;
    logic [PACK*PXL_W-1:0]  data_q, data_d;
    logic                   wren_q, wren_d, done_q, done_d, err_q, err_d, busy_q;
    logic                   frame_start, en, push, clear, word_full;
    logic [LIDX_W-1:0]      lane;
    logic [PACK*PXL_W-1:0]  word;

    assign en          = bus.iCCD_enable;
    assign frame_start = bus.iFVAL & ~fval_q;
    assign push = en && bus.iDVAL && bus.iFVAL &&
                  ((state_q == CAPTURE) || ((state_q == WAIT) && frame_start));
    // Any path back to IDLE except a completed full-word finish drops the pending lanes
    assign clear = ((state_q == IDLE) && en && bus.iCCD_start) ||
                   ((state_q != IDLE) && !en) ||
                   ((state_q == CAPTURE) && !bus.iFVAL) ||
                   (state_q == FLUSH);

    pixel_packer #(.PXL_W(PXL_W), .PACK(PACK), .LIDX_W(LIDX_W)) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .clear_i    (clear),
        .pixel_i    (bus.iDATA),
        .word_o     (word),
        .word_full_o(word_full),
        .lane_o     (lane)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        waddr_d = waddr_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: if (en && bus.iCCD_start) begin
                err_d   = 1'b0;
                cnt_d   = '0;
                addr_d  = ADDR_W'(BASE_ADDR);
                state_d = ARM;
            end
            ARM:     if (!bus.iFVAL) state_d = WAIT;
            WAIT:    if (frame_start) state_d = CAPTURE;
            CAPTURE: if (!bus.iFVAL) begin
                err_d   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            FLUSH: begin
                wren_d  = 1'b1;
                data_d  = word;
                waddr_d = addr_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (push) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (word_full) begin
                wren_d  = 1'b1;
                data_d  = word;
                waddr_d = addr_q;
                addr_d  = addr_q + ADDR_W'(1);
            end
            if (cnt_q + CNT_W'(1) == LAST_CNT) begin
                if (lane != LIDX_W'(PACK - 1)) begin
                    state_d = FLUSH;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        end
        // Enable drop wins over everything, including a write due this cycle
        if ((state_q != IDLE) && !en) begin
            state_d = IDLE;
            wren_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fval_q  <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            waddr_q <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fval_q  <= bus.iFVAL;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.oDmem_wren = wren_q;
    assign bus.oDmem_addr = waddr_q;
    assign bus.oDmem_data = data_q;
    assign bus.oCCD_busy  = busy_q;
    assign bus.oCCD_done  = done_q;
    assign bus.oCCD_err   = err_q;
endmodule

// File: tb/tb_img_capture_packer.sv
// Two configurations (784/16 and 20/8) share one CCD stream and are checked against a frame-level model.
module tb_img_capture_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, start = 1'b0, fval = 1'b0, dval = 1'b0;
    logic [15:0] data = '0;

    always #5 clk = ~clk;

    img_capture_packer_if #(.PXL_W(16), .PACK(16), .ADDR_W(7)) if0 ();
    img_capture_packer_if #(.PXL_W(16), .PACK(8),  .ADDR_W(7)) if1 ();

    assign if0.iCCD_enable = en;  assign if1.iCCD_enable = en;
    assign if0.iCCD_start  = start; assign if1.iCCD_start = start;
    assign if0.iFVAL = fval; assign if1.iFVAL = fval;
    assign if0.iDVAL = dval; assign if1.iDVAL = dval;
    assign if0.iDATA = data; assign if1.iDATA = data;

    img_capture_packer #(.PXL_W(16), .IMG_PIXELS(784), .PACK(16), .ADDR_W(7), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    img_capture_packer #(.PXL_W(16), .IMG_PIXELS(20), .PACK(8), .ADDR_W(7), .BASE_ADDR(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    logic         a_wren[2], a_done[2], a_err[2], a_busy[2];
    logic [6:0]   a_addr[2];
    logic [255:0] a_data[2];
    assign a_wren[0] = if0.oDmem_wren; assign a_wren[1] = if1.oDmem_wren;
    assign a_done[0] = if0.oCCD_done;  assign a_done[1] = if1.oCCD_done;
    assign a_err[0]  = if0.oCCD_err;   assign a_err[1]  = if1.oCCD_err;
    assign a_busy[0] = if0.oCCD_busy;  assign a_busy[1] = if1.oCCD_busy;
    assign a_addr[0] = if0.oDmem_addr; assign a_addr[1] = if1.oDmem_addr;
    assign a_data[0] = if0.oDmem_data; assign a_data[1] = {128'b0, if1.oDmem_data};

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int IMGc[2] = '{784, 20};
    int PKc[2]  = '{16, 8};
    int mode[2];            // 0 idle, 1 wait quiet, 2 wait rise, 3 capturing, 4 flush due
    int cnt[2];
    logic [15:0]  fp[2][1024];
    bit           e_wren[2], e_done[2], e_err[2], e_busy[2];
    int           e_addr[2];
    logic [255:0] e_data[2];
    bit           prev_fval;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0; cnt[i] = 0; e_wren[i] = 0; e_done[i] = 0;
            e_err[i] = 0; e_busy[i] = 0; e_addr[i] = 0; e_data[i] = '0;
        end
        prev_fval = 0;
    endtask

    task automatic emit(input int i, input int w);
        e_wren[i] = 1;
        e_addr[i] = w;
        e_data[i] = '0;
        for (int k = 0; k < PKc[i]; k++)
            if (w * PKc[i] + k < cnt[i]) e_data[i][k*16 +: 16] = fp[i][w * PKc[i] + k];
    endtask

    task automatic take(input int i);
        fp[i][cnt[i]] = data;
        cnt[i]++;
        if (cnt[i] % PKc[i] == 0) emit(i, cnt[i] / PKc[i] - 1);
        if (cnt[i] == IMGc[i]) begin
            if (cnt[i] % PKc[i] == 0) begin e_done[i] = 1; mode[i] = 0; end
            else mode[i] = 4;
        end
    endtask

    task automatic model_step(input int i);
        e_wren[i] = 0;
        e_done[i] = 0;
        if (mode[i] != 0 && !en) mode[i] = 0;
        else case (mode[i])
            0: if (en && start) begin e_err[i] = 0; cnt[i] = 0; mode[i] = 1; end
            1: if (!fval) mode[i] = 2;
            2: if (fval && !prev_fval) begin mode[i] = 3; if (dval) take(i); end
            3: if (!fval) begin e_err[i] = 1; e_done[i] = 1; mode[i] = 0; end
               else if (dval) take(i);
            4: begin emit(i, cnt[i] / PKc[i]); e_done[i] = 1; mode[i] = 0; end
            default: mode[i] = 0;
        endcase
        e_busy[i] = (mode[i] != 0);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else begin
                model_step(0);
                model_step(1);
                prev_fval = fval;
            end
        end
    end

    // ---------------- compare and write log ----------------
    logic [255:0] logdata[2][64];
    int           logaddr[2][64];
    bit           logdone[2][64];
    int           lcnt[2], ndn[2];

    initial begin
        lcnt = '{0, 0}; ndn = '{0, 0};
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("wren%0d", i), a_wren[i], e_wren[i]);
                    chk($sformatf("done%0d", i), a_done[i], e_done[i]);
                    chk($sformatf("err%0d", i),  a_err[i],  e_err[i]);
                    chk($sformatf("busy%0d", i), a_busy[i], e_busy[i]);
                    if (e_wren[i]) begin
                        chk($sformatf("addr%0d", i), a_addr[i], e_addr[i]);
                        chk($sformatf("data%0d", i), a_data[i], e_data[i]);
                    end
                    if (a_wren[i] && lcnt[i] < 64) begin
                        logdata[i][lcnt[i]] = a_data[i];
                        logaddr[i][lcnt[i]] = a_addr[i];
                        logdone[i][lcnt[i]] = a_done[i];
                        lcnt[i]++;
                    end
                    if (a_done[i] && !a_wren[i]) ndn[i]++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        lcnt = '{0, 0};
        ndn  = '{0, 0};
    endtask

    task automatic start_cap();
        en = 1; start = 1; cyc();
        start = 0; cyc();
    endtask

    task automatic frame(input int n, input int gap, input int base, input bit rnd);
        int i = 0;
        fval = 1;
        while (i < n) begin
            dval  = ($urandom_range(99) >= gap);
            data  = rnd ? 16'($urandom) : 16'(base + i);
            start = rnd && ($urandom_range(15) == 0);
            if (dval) i++;
            cyc();
        end
        dval = 0; fval = 0; start = 0;
        repeat (3) cyc();
    endtask

    initial begin
        logic [255:0] w;
        repeat (3) cyc();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_wren%0d", i), a_wren[i], 0);
            chk($sformatf("rst_addr%0d", i), a_addr[i], 0);
            chk($sformatf("rst_data%0d", i), a_data[i], 0);
            chk($sformatf("rst_busy%0d", i), a_busy[i], 0);
            chk($sformatf("rst_done%0d", i), a_done[i], 0);
            chk($sformatf("rst_err%0d", i),  a_err[i],  0);
        end
        rst_n = 1;
        cyc();

        // full frame, data = pixel index
        clear_log();
        start_cap();
        frame(784, 0, 0, 0);
        repeat (3) cyc();
        chk("t1_writes0", lcnt[0], 49);
        for (int k = 0; k < 16; k++) chk($sformatf("t1_w0_lane%0d", k), logdata[0][0][k*16 +: 16], k);
        chk("t1_lastaddr0", logaddr[0][48], 48);
        chk("t1_lastdone0", logdone[0][48], 1);
        chk("t1_predone0", logdone[0][47], 0);
        chk("t1_err0", a_err[0], 0);
        chk("t1_writes1", lcnt[1], 3);
        chk("t1_addr2_1", logaddr[1][2], 2);
        chk("t1_flushword1", logdata[1][2], 256'h0000_0000_0000_0000_0013_0012_0011_0010);
        chk("t1_flushdone1", logdone[1][2], 1);

        // start issued mid-frame
        clear_log();
        fval = 1; dval = 1;
        for (int i = 0; i < 10; i++) begin
            data = 16'(500 + i);
            start = (i == 5);
            cyc();
        end
        fval = 0; dval = 0; start = 0;
        repeat (3) cyc();
        frame(784, 0, 1000, 0);
        repeat (3) cyc();
        chk("t2_writes0", lcnt[0], 49);
        chk("t2_firstaddr0", logaddr[0][0], 0);
        chk("t2_firstpix0", logdata[0][0][15:0], 1000);
        chk("t2_firstpix1", logdata[1][0][15:0], 1000);

        // short frame
        clear_log();
        start_cap();
        frame(100, 0, 2000, 0);
        repeat (3) cyc();
        chk("t3_writes0", lcnt[0], 6);
        chk("t3_err0", a_err[0], 1);
        chk("t3_donenowr0", ndn[0], 1);
        chk("t3_writes1", lcnt[1], 3);
        chk("t3_err1", a_err[1], 0);

        // enable drop mid-frame
        clear_log();
        start_cap();
        chk("t4_errclr0", a_err[0], 0);
        fval = 1; dval = 1;
        for (int i = 0; i < 300; i++) begin data = 16'(3000 + i); cyc(); end
        en = 0; data = 16'(3300); cyc();
        chk("t4_busy0", a_busy[0], 0);
        for (int i = 0; i < 50; i++) begin data = 16'(3301 + i); cyc(); end
        fval = 0; dval = 0;
        repeat (3) cyc();
        chk("t4_writes0", lcnt[0], 18);
        chk("t4_donenowr0", ndn[0], 0);
        chk("t4_err0", a_err[0], 0);
        en = 1;

        // 50% gaps, 900 pixels in a 784-pixel frame
        clear_log();
        start_cap();
        frame(900, 50, 0, 0);
        repeat (3) cyc();
        chk("t5_writes0", lcnt[0], 49);
        for (int wi = 0; wi < 49; wi++) begin
            w = '0;
            for (int k = 0; k < 16; k++) w[k*16 +: 16] = 16'(wi * 16 + k);
            chk($sformatf("t5_word%0d", wi), logdata[0][wi], w);
        end

        // random data, gap rates and lengths, with stray start requests
        for (int r = 0; r < 4; r++) begin
            clear_log();
            start_cap();
            frame($urandom_range(10, 850), $urandom_range(0, 60), 0, 1);
            repeat (3) cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
